// File: rtl/id_exe_reg.sv
// id_exe_reg: pipeline register between the decode stage and the execute stage.
//
// Captures the decode control word, operand values, immediate fields and
// register indices, and presents them to EXE one cycle later.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               load a bubble (all-zero slot, valid_out=0); beats freeze
//   freeze              hold the current slot contents
//   *_in                control word and data fields from decode
//   *_out               registered copies of the *_in fields
//   valid_out           1 when the EXE slot holds a real instruction
//
// Every output is driven straight from a flop, so there is no combinational
// path from input to output. A bubble is bit-identical to the reset state.
module id_exe_reg #(
    parameter int WORD = 32,
    parameter int REGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            freeze,

    input  logic [3:0]      EXE_CMD_in,
    input  logic            WB_EN_in,
    input  logic            MEM_R_EN_in,
    input  logic            MEM_W_EN_in,
    input  logic            B_in,
    input  logic            S_in,
    input  logic [WORD-1:0] PC_in,
    input  logic [WORD-1:0] Val_Rn_in,
    input  logic [WORD-1:0] Val_Rm_in,
    input  logic            imm_in,
    input  logic [11:0]     shift_operand_in,
    input  logic [23:0]     signed_imm_24_in,
    input  logic [REGW-1:0] Dest_in,
    input  logic [REGW-1:0] src1_in,
    input  logic [REGW-1:0] src2_in,
    input  logic            C_in,

    output logic [3:0]      EXE_CMD_out,
    output logic            WB_EN_out,
    output logic            MEM_R_EN_out,
    output logic            MEM_W_EN_out,
    output logic            B_out,
    output logic            S_out,
    output logic [WORD-1:0] PC_out,
    output logic [WORD-1:0] Val_Rn_out,
    output logic [WORD-1:0] Val_Rm_out,
    output logic            imm_out,
    output logic [11:0]     shift_operand_out,
    output logic [23:0]     signed_imm_24_out,
    output logic [REGW-1:0] Dest_out,
    output logic [REGW-1:0] src1_out,
    output logic [REGW-1:0] src2_out,
    output logic            C_out,
    output logic            valid_out
);

    // Priority: rst (async) > flush > freeze > load.
    // Reset and flush clear identically so a bubble can never write the
    // register file, touch memory, branch or update status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EXE_CMD_out       <= '0;
            WB_EN_out         <= 1'b0;
            MEM_R_EN_out      <= 1'b0;
            MEM_W_EN_out      <= 1'b0;
            B_out             <= 1'b0;
            S_out             <= 1'b0;
            PC_out            <= '0;
            Val_Rn_out        <= '0;
            Val_Rm_out        <= '0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            Dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            C_out             <= 1'b0;
            valid_out         <= 1'b0;
        end else if (flush) begin
            EXE_CMD_out       <= '0;
            WB_EN_out         <= 1'b0;
            MEM_R_EN_out      <= 1'b0;
            MEM_W_EN_out      <= 1'b0;
            B_out             <= 1'b0;
            S_out             <= 1'b0;
            PC_out            <= '0;
            Val_Rn_out        <= '0;
            Val_Rm_out        <= '0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            Dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            C_out             <= 1'b0;
            valid_out         <= 1'b0;
        end else if (!freeze) begin
            EXE_CMD_out       <= EXE_CMD_in;
            WB_EN_out         <= WB_EN_in;
            MEM_R_EN_out      <= MEM_R_EN_in;
            MEM_W_EN_out      <= MEM_W_EN_in;
            B_out             <= B_in;
            S_out             <= S_in;
            PC_out            <= PC_in;
            Val_Rn_out        <= Val_Rn_in;
            Val_Rm_out        <= Val_Rm_in;
            imm_out           <= imm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm_24_out <= signed_imm_24_in;
            Dest_out          <= Dest_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            C_out             <= C_in;
            valid_out         <= 1'b1;
        end
    end

endmodule
